i2c_txn_ctrl: RTL and testbench



---
 rtl/i2c_txn_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_txn_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_ctrl.sv
// i2c_txn_ctrl: register-level I2C transaction sequencer with a two-port
// round-robin arbiter, sitting in front of a byte-level I2C engine.
//
// A granted request (write or read of 1 or 2 data bytes) is expanded into a
// list of engine primitives (START / STOP / READ_BYTE / WRITE_BYTE). Each
// primitive is issued with a one-cycle enable pulse, then the sequencer waits
// for a rising edge on the engine's complete flag. A watchdog aborts any
// single operation that takes longer than TIMEOUT_CYCLES.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   req[1:0]           per-requester request, held until its done bit
//   req_rw/req_len     per-requester: 1 = read / 1 = two data bytes
//   req_dev[13:0]      per-requester 7-bit device address
//   req_reg[15:0]      per-requester 8-bit register pointer
//   req_wdata[31:0]    per-requester write data, high byte sent first
//   done[1:0]          one-cycle completion pulse to the granted requester
//   err                with done: 1 = watchdog abort
//   rdata[15:0]        with done: read data
//   busy               high whenever not idle
//   instruction/enable/byte_to_send/send_nack  command to the engine
//   byte_received/complete                     response from the engine

module i2c_txn_ctrl #(
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rw,
  input  logic [1:0]  req_len,
  input  logic [13:0] req_dev,
  input  logic [15:0] req_reg,
  input  logic [31:0] req_wdata,
  output logic [1:0]  done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  instruction,
  output logic        enable,
  output logic [7:0]  byte_to_send,
  output logic        send_nack,
  input  logic [7:0]  byte_received,
  input  logic        complete
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] I_START = 2'd0;
  localparam logic [1:0] I_STOP  = 2'd1;
  localparam logic [1:0] I_RD    = 2'd2;
  localparam logic [1:0] I_WR    = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        rw;
    logic        len;
    logic [6:0]  dev;
    logic [7:0]  rgp;
    logic [15:0] wdata;
  } txn_t;

  state_t          state;
  txn_t            fld [2];
  txn_t            cur;
  logic            gnt, grant, last_grant;
  logic [2:0]      step, last_step;
  logic [WD_W-1:0] wd;
  logic            complete_d, cpl_edge;
  logic [15:0]     rd_buf;

  for (genvar n = 0; n < 2; n++) begin : g_fld
    assign fld[n] = {req_rw[n], req_len[n], req_dev[7*n +: 7],
                     req_reg[8*n +: 8], req_wdata[16*n +: 16]};
  end

  // Round robin: on contention take the requester not served last time.
  always_comb begin
    gnt = 1'b0;
    if (req[0] && req[1]) gnt = ~last_grant;
    else                  gnt = req[1];
  end

  // Index of the final (STOP) operation of the latched transaction.
  always_comb begin
    last_step = 3'd4;
    if (cur.rw) last_step = cur.len ? 3'd7 : 3'd6;
    else        last_step = cur.len ? 3'd5 : 3'd4;
  end

  // The engine drops complete when it samples enable, so only a fresh rising
  // edge can mean the operation just issued has finished.
  assign cpl_edge  = complete & ~complete_d;
  assign send_nack = 1'b0;

  // {instruction, byte} for step s of transaction t.
  function automatic logic [9:0] op_of(input txn_t t, input logic [2:0] s);
    logic [7:0] aw, ar;
    aw = {t.dev, 1'b0};
    ar = {t.dev, 1'b1};
    op_of = {I_STOP, 8'h00};
    if (!t.rw) begin
      case (s)
        3'd0:    op_of = {I_START, 8'h00};
        3'd1:    op_of = {I_WR, aw};
        3'd2:    op_of = {I_WR, t.rgp};
        3'd3:    op_of = {I_WR, t.wdata[15:8]};
        3'd4:    op_of = t.len ? {I_WR, t.wdata[7:0]} : {I_STOP, 8'h00};
        default: op_of = {I_STOP, 8'h00};
      endcase
    end else begin
      case (s)
        3'd0:    op_of = {I_START, 8'h00};
        3'd1:    op_of = {I_WR, aw};
        3'd2:    op_of = {I_WR, t.rgp};
        3'd3:    op_of = {I_START, 8'h00};
        3'd4:    op_of = {I_WR, ar};
        3'd5:    op_of = {I_RD, 8'h00};
        3'd6:    op_of = t.len ? {I_RD, 8'h00} : {I_STOP, 8'h00};
        default: op_of = {I_STOP, 8'h00};
      endcase
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur          <= '0;
      grant        <= 1'b1;
      last_grant   <= 1'b1;
      step         <= '0;
      wd           <= '0;
      complete_d   <= 1'b0;
      rd_buf       <= '0;
      done         <= '0;
      err          <= 1'b0;
      rdata        <= '0;
      busy         <= 1'b0;
      enable       <= 1'b0;
      instruction  <= '0;
      byte_to_send <= '0;
    end else begin
      complete_d <= complete;
      done       <= '0;
      enable     <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            cur        <= fld[gnt];
            grant      <= gnt;
            last_grant <= gnt;
            step       <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            rd_buf     <= '0;
            {instruction, byte_to_send} <= op_of(fld[gnt], 3'd0);
            enable     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cpl_edge) begin
            // Shifting in keeps a 1-byte read as {00, b0} and a 2-byte read
            // as {b0, b1}.
            if (instruction == I_RD) rd_buf <= {rd_buf[7:0], byte_received};
            if (step == last_step) begin
              done[grant] <= 1'b1;
              rdata       <= cur.rw ? rd_buf : 16'h0000;
              state       <= DONE;
            end else begin
              step   <= step + 3'd1;
              {instruction, byte_to_send} <= op_of(cur, step + 3'd1);
              enable <= 1'b1;
              state  <= ISSUE;
            end
          end else if (wd == WD_MAX) begin
            // Abort without a STOP; the counter holds here rather than wrap.
            err         <= 1'b1;
            rdata       <= '0;
            done[grant] <= 1'b1;
            state       <= DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// Self-checking bench for i2c_txn_ctrl. A behavioural engine model accepts
// enables (ignored while busy), answers after a random latency by raising
// complete (held high until the next accepted enable) and logs every
// accepted operation. Expected operation lists, read data, arbitration order
// and latencies are rebuilt from the transaction rules.

module tb_i2c_txn_ctrl;

  localparam int TO = 64;

  logic        clk, reset;
  logic [1:0]  req, req_rw, req_len;
  logic [13:0] req_dev;
  logic [15:0] req_reg;
  logic [31:0] req_wdata;
  logic [1:0]  done;
  logic        err;
  logic [15:0] rdata;
  logic        busy;
  logic [1:0]  instruction;
  logic        enable;
  logic [7:0]  byte_to_send;
  logic        send_nack;
  logic [7:0]  byte_received;
  logic        complete;

  i2c_txn_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_len(req_len),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy),
    .instruction(instruction), .enable(enable), .byte_to_send(byte_to_send),
    .send_nack(send_nack), .byte_received(byte_received), .complete(complete)
  );

  int checks, failures;
  int cyc, en_pulses;

  // engine model state (written only by the engine process)
  int          n_ops, eng_cnt, cur_idx, rx_k;
  bit          stuck;
  logic [1:0]  cur_instr;
  logic [9:0]  op_rec  [4096];
  int          en_cyc  [4096];
  int          cpl_cyc [4096];
  logic [7:0]  rx_b    [4096];

  // engine controls (written only by the main process)
  int          hang_idx;
  bit          rx_fix;
  logic [7:0]  rx_fix0, rx_fix1;

  // requester-side transaction fields
  bit          f_rw [2];
  bit          f_len[2];
  logic [6:0]  f_dev[2];
  logic [7:0]  f_reg[2];
  logic [15:0] f_wd [2];
  logic [9:0]  exp_ops[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    en_pulses = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (enable === 1'b1) en_pulses++;
    end
  end

  // Engine model, evaluated on the falling edge.
  initial begin
    logic [7:0] b;
    complete = 1'b1;  // stale high before the first operation
    byte_received = 8'h00;
    eng_cnt = 0; stuck = 1'b0; rx_k = 0; n_ops = 0; cur_idx = 0; cur_instr = 2'd0;
    forever begin
      @(negedge clk);
      if (stuck) begin
        if (hang_idx < 0) stuck = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          if (cur_instr == 2'd2) begin
            b = rx_fix ? ((rx_k == 0) ? rx_fix0 : rx_fix1) : 8'($urandom);
            rx_k++;
            byte_received = b;
            rx_b[cur_idx] = b;
          end
          complete = 1'b1;
          cpl_cyc[cur_idx] = cyc;
        end
      end else if (enable === 1'b1) begin
        cur_idx = n_ops;
        n_ops++;
        cur_instr = instruction;
        op_rec[cur_idx] = {instruction, (instruction == 2'd3) ? byte_to_send : 8'h00};
        en_cyc[cur_idx] = cyc;
        complete = 1'b0;
        if (cur_idx == hang_idx) stuck = 1'b1;
        else eng_cnt = $urandom_range(2, 12);
      end
      if (!rx_fix) rx_k = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic drive(input int n);
    req_rw[n]            = f_rw[n];
    req_len[n]           = f_len[n];
    req_dev[7*n +: 7]    = f_dev[n];
    req_reg[8*n +: 8]    = f_reg[n];
    req_wdata[16*n +: 16] = f_wd[n];
  endtask

  task automatic scramble(input int n);
    req_rw[n]             = 1'($urandom);
    req_len[n]            = 1'($urandom);
    req_dev[7*n +: 7]     = 7'($urandom);
    req_reg[8*n +: 8]     = 8'($urandom);
    req_wdata[16*n +: 16] = 16'($urandom);
  endtask

  task automatic rand_fields(input int n);
    f_rw[n]  = 1'($urandom);
    f_len[n] = 1'($urandom);
    f_dev[n] = 7'($urandom);
    f_reg[n] = 8'($urandom);
    f_wd[n]  = 16'($urandom);
  endtask

  // Expected engine primitives for requester n's transaction.
  task automatic expect_ops(input int n);
    exp_ops.delete();
    exp_ops.push_back({2'd0, 8'h00});
    exp_ops.push_back({2'd3, f_dev[n], 1'b0});
    exp_ops.push_back({2'd3, f_reg[n]});
    if (!f_rw[n]) begin
      exp_ops.push_back({2'd3, f_wd[n][15:8]});
      if (f_len[n]) exp_ops.push_back({2'd3, f_wd[n][7:0]});
    end else begin
      exp_ops.push_back({2'd0, 8'h00});
      exp_ops.push_back({2'd3, f_dev[n], 1'b1});
      exp_ops.push_back({2'd2, 8'h00});
      if (f_len[n]) exp_ops.push_back({2'd2, 8'h00});
    end
    exp_ops.push_back({2'd1, 8'h00});
  endtask

  task automatic wait_done(output int dc, output logic [1:0] who);
    dc = -1;
    who = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        dc = cyc;
        who = done;
        break;
      end
    end
    chk("done_seen", (dc >= 0), 1);
  endtask

  task automatic verify(input int n, input logic [1:0] who, input int dc,
                        input int base, input int ebase);
    int nops;
    logic [7:0] rb[$];
    logic [15:0] exp_rd;
    nops = n_ops - base;
    expect_ops(n);
    chk("grant", who, (n == 0) ? 2'b01 : 2'b10);
    chk("err", err, 0);
    chk("op_count", nops, exp_ops.size());
    chk("enable_count", en_pulses - ebase, exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < nops; i++) begin
      chk("op", op_rec[base+i], exp_ops[i]);
      if (op_rec[base+i][9:8] == 2'd2) rb.push_back(rx_b[base+i]);
    end
    for (int i = 0; i + 1 < nops; i++)
      chk("issue_gap", en_cyc[base+i+1], cpl_cyc[base+i] + 1);
    if (nops > 0) chk("done_lat", dc, cpl_cyc[base+nops-1] + 1);
    exp_rd = 16'h0000;
    if (f_rw[n]) begin
      if (f_len[n] && rb.size() > 1) exp_rd = {rb[0], rb[1]};
      else if (!f_len[n] && rb.size() > 0) exp_rd = {8'h00, rb[0]};
    end
    chk("rdata", rdata, exp_rd);
  endtask

  // Single requester transaction from an idle controller.
  task automatic run_one(input int n, output int base, output int ebase);
    int t0, dc;
    logic [1:0] who;
    repeat (2) @(negedge clk);
    drive(n);
    base = n_ops;
    ebase = en_pulses;
    t0 = cyc;
    req[n] = 1'b1;
    repeat (2) @(negedge clk);
    chk("grant_lat", (n_ops > base) ? en_cyc[base] : -1, t0 + 1);
    scramble(n);  // fields after grant must be ignored
    wait_done(dc, who);
    req[n] = 1'b0;
    verify(n, who, dc, base, ebase);
  endtask

  initial begin
    int base, ebase, dc, n, last_g, w;
    logic [1:0] who;
    checks = 0; failures = 0;
    reset = 1'b1;
    req = '0; req_rw = '0; req_len = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
    hang_idx = -1; rx_fix = 1'b0; rx_fix0 = 8'h00; rx_fix1 = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", enable, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_byte", byte_to_send, 0);
    chk("rst_nack", send_nack, 0);

    // Both requesters from reset, held continuously: 0,1,0,1.
    rand_fields(0); rand_fields(1);
    drive(0); drive(1);
    reset = 1'b0;
    req = 2'b11;
    base = n_ops; ebase = en_pulses;
    last_g = 1;
    for (int t = 0; t < 4; t++) begin
      wait_done(dc, who);
      w = 1 - last_g;
      chk("alt_order", who, (t % 2 == 0) ? 2'b01 : 2'b10);
      verify(w, who, dc, base, ebase);
      last_g = w;
      base = n_ops; ebase = en_pulses;
      if (t == 3) req = 2'b00;
      rand_fields(w);
      drive(w);
    end

    // Directed write: dev 0x40, reg 0x06, data 0x12xx, one byte.
    f_rw[0] = 1'b0; f_len[0] = 1'b0; f_dev[0] = 7'h40; f_reg[0] = 8'h06;
    f_wd[0] = {8'h12, 8'($urandom)};
    run_one(0, base, ebase);
    chk("wr_enables", en_pulses - ebase, 5);
    chk("wr_addr", op_rec[base+1], {2'd3, 8'h80});
    chk("wr_data", op_rec[base+3], {2'd3, 8'h12});

    // Directed read: dev 0x36, reg 0x0C, two bytes 0x0A, 0xBC.
    f_rw[1] = 1'b1; f_len[1] = 1'b1; f_dev[1] = 7'h36; f_reg[1] = 8'h0C; f_wd[1] = 16'h0000;
    rx_fix0 = 8'h0A; rx_fix1 = 8'hBC; rx_fix = 1'b1;
    run_one(1, base, ebase);
    chk("rd_rdata", rdata, 16'h0ABC);
    chk("rd_enables", en_pulses - ebase, 8);
    chk("rd_addr_r", op_rec[base+4], {2'd3, 8'h6D});
    rx_fix = 1'b0;

    // Random single transactions.
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 1);
      rand_fields(n);
      run_one(n, base, ebase);
    end

    // Watchdog: engine never completes the 2nd operation.
    n = $urandom_range(0, 1);
    rand_fields(n);
    repeat (2) @(negedge clk);
    drive(n);
    base = n_ops; ebase = en_pulses;
    hang_idx = n_ops + 1;
    req[n] = 1'b1;
    wait_done(dc, who);
    req[n] = 1'b0;
    chk("to_grant", who, (n == 0) ? 2'b01 : 2'b10);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    chk("to_enables", en_pulses - ebase, 2);
    chk("to_lat", dc, en_cyc[base+1] + TO + 1);
    @(negedge clk);
    chk("to_busy_fall", busy, 0);
    chk("to_done_pulse", done, 0);
    hang_idx = -1;
    repeat (2) @(negedge clk);

    // Reset during the 3rd WAIT, then a normal write once the engine is idle.
    rand_fields(0);
    f_rw[0] = 1'b0;
    drive(0);
    base = n_ops;
    req[0] = 1'b1;
    for (int i = 0; i < 500 && n_ops < base + 3; i++) @(negedge clk);
    chk("rst_mid_reached", n_ops - base, 3);
    @(negedge clk);
    chk("err_cleared", err, 0);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_enable", enable, 0);
    chk("arst_instr", instruction, 0);
    chk("arst_byte", byte_to_send, 0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100 && eng_cnt != 0; i++) @(negedge clk);
    chk("engine_idle", eng_cnt, 0);
    rand_fields(0);
    f_rw[0] = 1'b0;
    run_one(0, base, ebase);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
